vga_clk_gen: RTL and testbench

VGA_CLK_GEN -- requirements
Module: vga_clk_gen

---
 rtl/vga_clk_gen.sv | 150 +++++++++++++++
 tb/tb_vga_clk_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_clk_gen.sv
// Purpose : multi-channel NCO clock generator: one phase accumulator per channel, MSB driven out as a clock,
//           carry driven out as a one-cycle clock enable, plus a lock indicator that restarts on every reconfiguration.
// Latency : outputs registered; config writes take effect on the edge that samples them, lock rises LOCK_CYCLES edges after the last write.
// Backpressure: none; cfg port always accepts one write per cycle, invalid channel writes are dropped and flagged on cfg_err.
//
// Ports:
//   refclk    - single clock, all state on rising edge
//   rst       - synchronous active-low reset
//   cfg_wr    - one-cycle configuration write strobe
//   cfg_sel   - 0: write increment, 1: write phase (accumulator)
//   cfg_ch    - target channel index
//   cfg_data  - increment or phase value
//   cfg_err   - one-cycle pulse for a write to a non-existent channel
//   outclk    - per-channel generated clock (accumulator MSB)
//   clk_en    - per-channel one-cycle pulse after an accumulator wrap
//   locked    - high once no valid write has occurred for LOCK_CYCLES cycles

module vga_clk_gen #(
    parameter int                NUM_CLOCKS  = 2,
    parameter int                ACC_W       = 16,
    parameter int                LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0]  DEFAULT_INC = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_wr,
    input  logic                  cfg_sel,
    input  logic [2:0]            cfg_ch,
    input  logic [ACC_W-1:0]      cfg_data,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] clk_en,
    output logic                  locked
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [3:0]       NUM_CH   = 4'(NUM_CLOCKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic wr_ok;
    logic wr_bad;

    // Channel index widened by one bit so NUM_CLOCKS=8 compares correctly.
    assign wr_ok  = cfg_wr && ({1'b0, cfg_ch} < NUM_CH);
    assign wr_bad = cfg_wr && !({1'b0, cfg_ch} < NUM_CH);

    // ------------------------------------------------------------------
    // Per-channel phase accumulators
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] inc_q;
        logic             en_q;
        logic [ACC_W:0]   sum;
        logic             hit;

        // Extra top bit of the sum is the wrap carry that becomes clk_en.
        assign sum = {1'b0, acc_q} + {1'b0, inc_q};
        assign hit = wr_ok && (cfg_ch == 3'(i));

        always_ff @(posedge refclk) begin
            if (!rst) begin
                acc_q <= '0;
                inc_q <= DEFAULT_INC;
                en_q  <= 1'b0;
            end else begin
                // A phase load replaces the add, so no wrap can be reported.
                if (hit && cfg_sel) begin
                    acc_q <= cfg_data;
                    en_q  <= 1'b0;
                end else begin
                    acc_q <= sum[ACC_W-1:0];
                    en_q  <= sum[ACC_W];
                end
                // New increment is only seen by the add on the following edge.
                if (hit && !cfg_sel) begin
                    inc_q <= cfg_data;
                end
            end
        end

        assign outclk[i] = acc_q[ACC_W-1];
        assign clk_en[i] = en_q;
    end

    // ------------------------------------------------------------------
    // Invalid-write flag
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (!rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= wr_bad;
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (wr_ok) begin
            // Any reconfiguration restarts the settle window from scratch.
            state_d = SETTLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LOCKED: begin
                    state_d = LOCKED;
                end
                default: begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_clk_gen.sv
// Purpose : self-checking bench for vga_clk_gen (NUM_CLOCKS=2, ACC_W=16, LOCK_CYCLES=16).
// Latency : outputs sampled 1 ns after each rising edge and compared to a table and to an arithmetic model.
// Backpressure: not applicable; every loop is bounded by a fixed cycle count.

module tb_vga_clk_gen;

    localparam int NC = 2;
    localparam int AW = 16;
    localparam int LC = 16;

    logic          refclk = 1'b0;
    logic          rst;
    logic          cfg_wr;
    logic          cfg_sel;
    logic [2:0]    cfg_ch;
    logic [AW-1:0] cfg_data;
    logic          cfg_err;
    logic [NC-1:0] outclk;
    logic [NC-1:0] clk_en;
    logic          locked;

    always #5 refclk = ~refclk;

    vga_clk_gen #(
        .NUM_CLOCKS  (NC),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC),
        .DEFAULT_INC (16'h8000)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_wr   (cfg_wr),
        .cfg_sel  (cfg_sel),
        .cfg_ch   (cfg_ch),
        .cfg_data (cfg_data),
        .cfg_err  (cfg_err),
        .outclk   (outclk),
        .clk_en   (clk_en),
        .locked   (locked)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model: plain modular arithmetic ----------------
    longint unsigned m_acc [NC];
    longint unsigned m_inc [NC];
    bit              m_en  [NC];
    bit              m_err;
    int              m_quiet;   // edges since reset release or last valid write

    function automatic void model_step();
        bit valid;
        longint unsigned s;
        valid = cfg_wr && (int'(cfg_ch) < NC);
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                m_acc[i] = 0;
                m_inc[i] = 64'h8000;
                m_en[i]  = 0;
            end
            m_err   = 0;
            m_quiet = 0;
        end else begin
            m_err = cfg_wr && !valid;
            for (int i = 0; i < NC; i++) begin
                if (valid && cfg_sel && int'(cfg_ch) == i) begin
                    m_acc[i] = cfg_data;
                    m_en[i]  = 0;
                end else begin
                    s        = m_acc[i] + m_inc[i];
                    m_en[i]  = (s >= 65536);
                    m_acc[i] = s % 65536;
                end
            end
            if (valid && !cfg_sel) m_inc[cfg_ch] = cfg_data;
            if (valid) m_quiet = 0;
            else if (m_quiet < 1000) m_quiet++;
        end
    endfunction

    task automatic chk_model(input string tag);
        logic [NC-1:0] eo, ee;
        for (int i = 0; i < NC; i++) begin
            eo[i] = m_acc[i][15];
            ee[i] = m_en[i];
        end
        check({tag, " outclk"}, 32'(outclk), 32'(eo));
        check({tag, " clk_en"}, 32'(clk_en), 32'(ee));
        check({tag, " cfg_err"}, 32'(cfg_err), 32'(m_err));
        check({tag, " locked"}, 32'(locked), 32'(m_quiet >= LC));
    endtask

    task automatic drive(input bit r, input bit w, input bit s, input logic [2:0] c, input logic [15:0] d);
        rst = r; cfg_wr = w; cfg_sel = s; cfg_ch = c; cfg_data = d;
    endtask

    task automatic cyc();
        @(posedge refclk);
        model_step();
        #1;
    endtask

    // Release reset and verify the lock edge and the default divide-by-2 pattern.
    task automatic run_from_reset(input string tag);
        int first_lock = 0;
        drive(1, 0, 0, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            cyc();
            chk_model(tag);
            check({tag, " ch0 toggle"}, 32'(outclk[0]), 32'(n % 2));
            check({tag, " ch0 en"}, 32'(clk_en[0]), 32'(n % 2 == 0));
            if (locked && first_lock == 0) first_lock = n;
        end
        check({tag, " lock edge"}, 32'(first_lock), 32'(LC));
    endtask

    typedef struct {
        bit          r, w, s;
        logic [2:0]  c;
        logic [15:0] d;
        logic [1:0]  oc, en;
        bit          err, lk;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int low, hi1, bad;
        logic lvl;
        int pulses [$];

        //            r  w  s  ch   data      outclk  clk_en  err lk
        tbl[0]  = '{0, 0, 0, 3'd0, 16'h0000, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b11, 2'b00, 0, 0};
        tbl[2]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b00, 2'b11, 0, 0};
        tbl[3]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b11, 2'b00, 0, 0};
        tbl[4]  = '{1, 1, 0, 3'd5, 16'h1234, 2'b00, 2'b11, 1, 0};
        tbl[5]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b11, 2'b00, 0, 0};
        tbl[6]  = '{1, 1, 1, 3'd0, 16'hC000, 2'b01, 2'b10, 0, 0};
        tbl[7]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b10, 2'b01, 0, 0};
        tbl[8]  = '{1, 1, 0, 3'd1, 16'h4000, 2'b01, 2'b10, 0, 0};
        tbl[9]  = '{1, 0, 0, 3'd0, 16'h0000, 2'b00, 2'b01, 0, 0};
        tbl[10] = '{1, 0, 0, 3'd0, 16'h0000, 2'b11, 2'b00, 0, 0};
        tbl[11] = '{1, 0, 0, 3'd0, 16'h0000, 2'b10, 2'b01, 0, 0};
        tbl[12] = '{1, 0, 0, 3'd0, 16'h0000, 2'b01, 2'b10, 0, 0};
        tbl[13] = '{0, 1, 0, 3'd0, 16'h0000, 2'b00, 2'b00, 0, 0};
        tbl[14] = '{1, 0, 0, 3'd0, 16'h0000, 2'b11, 2'b00, 0, 0};

        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].r, tbl[k].w, tbl[k].s, tbl[k].c, tbl[k].d);
            cyc();
            check($sformatf("vec%0d outclk", k), 32'(outclk), 32'(tbl[k].oc));
            check($sformatf("vec%0d clk_en", k), 32'(clk_en), 32'(tbl[k].en));
            check($sformatf("vec%0d cfg_err", k), 32'(cfg_err), 32'(tbl[k].err));
            check($sformatf("vec%0d locked", k), 32'(locked), 32'(tbl[k].lk));
            chk_model($sformatf("vec%0d model", k));
        end

        // Clean reset, then lock timing with default increments.
        drive(0, 0, 0, 0, 0);
        cyc();
        chk_model("reset");
        run_from_reset("rel1");

        // Increment write on ch1 while locked: divide-by-4, lock drops for 16 cycles.
        drive(1, 1, 0, 1, 16'h4000);
        cyc();
        chk_model("inc1 wr");
        low = locked ? 0 : 1;
        hi1 = 0;
        drive(1, 0, 0, 0, 0);
        for (int n = 1; n <= 30; n++) begin
            cyc();
            chk_model("div4");
            if (!locked) low++;
            if (clk_en[1]) pulses.push_back(n);
            if (n >= 13 && n <= 28 && outclk[1]) hi1++;
        end
        check("div4 lock low cycles", 32'(low), 32'(LC));
        check("div4 outclk1 duty", 32'(hi1), 32'd8);
        check("div4 pulse count", 32'(pulses.size() >= 3), 32'd1);
        if (pulses.size() >= 3) begin
            check("div4 period a", 32'(pulses[1] - pulses[0]), 32'd4);
            check("div4 period b", 32'(pulses[2] - pulses[1]), 32'd4);
        end

        // Freeze ch0 with inc=0.
        drive(1, 1, 0, 0, 16'h0000);
        cyc();
        chk_model("freeze wr");
        lvl = outclk[0];
        bad = 0;
        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            cyc();
            chk_model("freeze");
            if (outclk[0] !== lvl || clk_en[0] !== 1'b0) bad++;
        end
        check("freeze violations", 32'(bad), 32'd0);
        check("freeze relocked", 32'(locked), 32'd1);

        // One-cycle reset while locked with a concurrent write that must be discarded.
        drive(0, 1, 0, 1, 16'h0000);
        cyc();
        check("mid rst outclk", 32'(outclk), 32'd0);
        check("mid rst clk_en", 32'(clk_en), 32'd0);
        check("mid rst locked", 32'(locked), 32'd0);
        check("mid rst cfg_err", 32'(cfg_err), 32'd0);
        chk_model("mid rst");
        run_from_reset("rel2");

        // Randomized traffic against the model: busy phase, then sparse phase.
        for (int n = 0; n < 600; n++) begin
            bit r, w;
            logic [15:0] d;
            r = ($urandom_range(0, 59) != 0);
            w = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            d = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            drive(r, w, 1'($urandom), 3'($urandom_range(0, 3)), d);
            cyc();
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
